ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the integer ALU in the 5-stage core.
- Captures decoded fields from ID and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards, inserts bubbles, and drives the ALU opcode/src1/src2 plus store data and writeback control toward EX/MEM.

Parameters:
- XLEN, 32, datapath width
- RADDR, 5, register-address width
- OPW, 4, ALU opcode width

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OPW  ALU opcode for the instruction
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr  in  RADDR  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_use_pc  in  1  src1 = PC instead of rs1
- id_use_imm  in  1  src2 = imm instead of rs2
- id_rd_addr  in  RADDR  destination register
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- mem_rd_addr, wb_rd_addr  in  RADDR  destinations in MEM and WB
- mem_rd_we, wb_rd_we  in  1  MEM/WB write enables (valid-qualified upstream)
- mem_fwd_data, wb_fwd_data  in  XLEN  result values in MEM and WB
- hold  in  1  global pipeline freeze (memory wait)
- flush  in  1  kill the instruction in ID (taken branch/jump)
- stall_id  out  1  load-use stall request to IF/ID
- ex_valid  out  1  EX holds a real instruction
- alu_opcode  out  OPW  to ALU opcode
- alu_src1, alu_src2  out  XLEN  to ALU operands
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_rd_addr  out  RADDR  EX destination register
- ex_rd_we  out  1  EX write enable (0 when invalid)
- ex_is_load  out  1  EX instruction is a load

Behaviour:
- Reset (rstn=0, asynchronous): all EX registers cleared. ex_valid=0, ex_rd_we=0, ex_is_load=0, alu_opcode=0, ex_rd_addr=0, all stored data=0. Output consequences: alu_src1=0, alu_src2=0, ex_store_data=0, stall_id=0.
- Reset mid-operation discards the EX instruction. No partial state survives.
- Load-use hazard (combinational):
  - stall_id = ex_valid & ex_is_load & ex_rd_we & (ex_rd_addr != 0) & id_valid & ((ex_rd_addr==id_rs1_addr & !id_use_pc) | (ex_rd_addr==id_rs2_addr)).
  - rs2 is always checked because the store data path needs it.
- EX register update on each clk rising edge. Priority: hold > flush > stall_id > load.
  - hold=1: all EX registers keep their value, including a bubble. stall_id is still driven.
  - flush=1: bubble (ex_valid=0, ex_rd_we=0, ex_is_load=0). Data fields don't-care, but must be clean zeros.
  - stall_id=1: bubble. IF/ID hold the instruction externally, so the consumer is re-presented next cycle.
  - Otherwise: capture all id_* fields. ex_rd_we = id_rd_we & id_valid & (id_rd_addr != 0).
- Forwarding (combinational, on registered rs addresses), applied independently for rs1 and rs2:
  - If mem_rd_we & mem_rd_addr==rs & rs!=0: use mem_fwd_data.
  - Else if wb_rd_we & wb_rd_addr==rs & rs!=0: use wb_fwd_data.
  - Else: use the registered RF data.
  - MEM has priority over WB (the younger producer wins).
  - x0 is never forwarded. The value is always the stored RF data (0).
  - Load results reach the consumer via WB after the single bubble. Hazard logic guarantees MEM never holds a matching load.
- Operand select:
  - alu_src1 = use_pc ? pc : fwd_rs1.
  - alu_src2 = use_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
  - alu_opcode = registered opcode.
- Latency: one cycle from ID capture to ALU operands.
- Throughput: one instruction per cycle except for a load-use stall (exactly one bubble) or hold.
- Widths: no arithmetic, pure selection. All data paths are XLEN with no truncation.
- Simultaneous flush and stall_id: bubble (same result). flush wins for bookkeeping.
- Simultaneous hold and flush: hold wins. flush must be held by its source until hold drops.

Test Plan:
- Reset mid-stream: valid ADD captured, rstn pulsed low between edges -> ex_valid=0 and alu_src1=alu_src2=0 immediately, with no clock needed.
- MEM vs WB priority: EX rs1=5; mem_rd_addr=5, mem_fwd_data=0x11; wb_rd_addr=5, wb_fwd_data=0x22 (both we=1) -> alu_src1=0x11. Drop mem_rd_we -> alu_src1=0x22.
- x0 guard: EX rs2=0, use_imm=0; mem_rd_addr=0, mem_rd_we=1, mem_fwd_data=0xDEAD -> alu_src2=0, ex_store_data=0.
- Load-use: EX holds LW x7 (is_load, rd_we). ID has ADD with rs1=7 -> stall_id=1, next edge ex_valid=0. Then WB holds x7=0x1234 -> ADD captured with alu_src1=0x1234.
- Flush with stall: flush=1 and stall_id=1 on the same edge -> bubble. With hold=1 also asserted -> EX unchanged.
- Immediate/PC select: id_use_pc=1, id_pc=0x100, id_use_imm=1, id_imm=0xFFFFFFFC -> alu_src1=0x100, alu_src2=0xFFFFFFFC, ex_store_data = forwarded rs2.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX register and ALU operand select with MEM/WB forwarding.
// Load-use detection inserts a single bubble ahead of the consumer.
module ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [OPW-1:0]   id_opcode,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RADDR-1:0] id_rs1_addr,
    input  logic [RADDR-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic             id_use_pc,
    input  logic             id_use_imm,
    input  logic [RADDR-1:0] id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic [RADDR-1:0] mem_rd_addr,
    input  logic [RADDR-1:0] wb_rd_addr,
    input  logic             mem_rd_we,
    input  logic             wb_rd_we,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic [XLEN-1:0]  wb_fwd_data,
    input  logic             hold,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [OPW-1:0]   alu_opcode,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_rd_addr,
    output logic             ex_rd_we,
    output logic             ex_is_load
);

    logic             r_valid;
    logic [OPW-1:0]   r_opcode;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [RADDR-1:0] r_rs1_addr;
    logic [RADDR-1:0] r_rs2_addr;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic             r_use_pc;
    logic             r_use_imm;
    logic [RADDR-1:0] r_rd_addr;
    logic             r_rd_we;
    logic             r_is_load;

    logic             w_stall;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // rs2 is checked even for imm forms because store data needs it
    assign w_rs1_hit = (r_rd_addr == id_rs1_addr) && !id_use_pc;
    assign w_rs2_hit = (r_rd_addr == id_rs2_addr);
    assign w_stall   = r_valid && r_is_load && r_rd_we
                    && (r_rd_addr != '0) && id_valid
                    && (w_rs1_hit || w_rs2_hit);

    function automatic logic [XLEN-1:0] fwd(
        input logic [RADDR-1:0] rs,
        input logic [XLEN-1:0]  rf
    );
        if (mem_rd_we && (mem_rd_addr == rs) && (rs != '0))
            return mem_fwd_data;
        else if (wb_rd_we && (wb_rd_addr == rs) && (rs != '0))
            return wb_fwd_data;
        else
            return rf;
    endfunction

    assign w_fwd_rs1 = fwd(r_rs1_addr, r_rs1_data);
    assign w_fwd_rs2 = fwd(r_rs2_addr, r_rs2_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid    <= 1'b0;
            r_opcode   <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_use_pc   <= 1'b0;
            r_use_imm  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (hold) begin
            r_valid <= r_valid;
        end else if (flush || w_stall) begin
            // bubbles carry clean zeros so stale data never reaches the ALU
            r_valid    <= 1'b0;
            r_opcode   <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_use_pc   <= 1'b0;
            r_use_imm  <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
        end else begin
            r_valid    <= id_valid;
            r_opcode   <= id_opcode;
            r_pc       <= id_pc;
            r_imm      <= id_imm;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_use_pc   <= id_use_pc;
            r_use_imm  <= id_use_imm;
            r_rd_addr  <= id_rd_addr;
            r_rd_we    <= id_rd_we && id_valid && (id_rd_addr != '0);
            r_is_load  <= id_is_load;
        end
    end

    assign stall_id      = w_stall;
    assign ex_valid      = r_valid;
    assign alu_opcode    = r_opcode;
    assign alu_src1      = r_use_pc  ? r_pc  : w_fwd_rs1;
    assign alu_src2      = r_use_imm ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_rd_we      = r_rd_we;
    assign ex_is_load    = r_is_load;

endmodule
